// File: rtl/lsu_if.sv
// ============================================================================
//  Module : lsu_if
//  Brief  : Data-memory request/grant + read-valid bus between LSU and memory.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

interface lsu_if;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, addr, wen, wdata, mask,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, wen, wdata, mask,
        output gnt, rvalid, rdata
    );
endinterface

`default_nettype wire

// File: rtl/lsu.sv
// ============================================================================
//  Module : lsu
//  Brief  : Memory-stage load/store unit: aligns stores, extends loads, flags
//           misaligned/illegal ops and bus timeouts. One op in flight.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module lsu #(
    parameter int TIMEOUT = 64
) (
    input  wire logic        i_clk,
    input  wire logic        i_rst,
    input  wire logic        i_valid,
    output logic             o_ready,
    input  wire logic [31:0] i_addr,
    input  wire logic [31:0] i_wdata,
    input  wire logic        i_ren,
    input  wire logic        i_wen,
    input  wire logic [2:0]  i_funct3,
    lsu_if.master            dmem,
    output logic             o_valid,
    input  wire logic        i_ready,
    output logic [31:0]      o_rdata,
    output logic             o_misaligned,
    output logic             o_fault
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  wdata_q, wdata_d;
    logic [3:0]   mask_q, mask_d;
    logic [2:0]   f3_q, f3_d;
    logic         wen_q, wen_d;
    logic [31:0]  rdata_q, rdata_d;
    logic         mis_q, mis_d;
    logic         fault_q, fault_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [15:0]  w_half;
    logic [7:0]   w_byte;
    logic [31:0]  w_load;
    logic         w_timeout;
    logic         w_illegal;
    logic         w_misal;

    assign w_half = addr_q[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
    assign w_byte = addr_q[0] ? w_half[15:8] : w_half[7:0];

    always_comb begin
        case (f3_q)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = dmem.rdata;
        endcase
    end

    // Counter is cleared on entry to REQ, so hitting TIMEOUT-1 here means
    // this is the TIMEOUT-th cycle spent waiting on the bus.
    assign w_timeout = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

    assign w_illegal = (i_funct3 == 3'b011) || (i_funct3 == 3'b110) || (i_funct3 == 3'b111);
    assign w_misal   = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                       ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        f3_d    = f3_q;
        wen_d   = wen_q;
        rdata_d = rdata_q;
        mis_d   = mis_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (i_valid && (i_ren || i_wen)) begin
                    addr_d  = i_addr;
                    f3_d    = i_funct3;
                    wen_d   = i_wen;
                    rdata_d = 32'd0;
                    mis_d   = 1'b0;
                    fault_d = 1'b0;
                    cnt_d   = '0;
                    case (i_funct3[1:0])
                        2'b00: begin
                            mask_d  = 4'b0001 << i_addr[1:0];
                            wdata_d = {4{i_wdata[7:0]}};
                        end
                        2'b01: begin
                            mask_d  = 4'b0011 << i_addr[1:0];
                            wdata_d = {2{i_wdata[15:0]}};
                        end
                        default: begin
                            mask_d  = 4'b1111;
                            wdata_d = i_wdata;
                        end
                    endcase
                    if (w_illegal) begin
                        fault_d = 1'b1;
                        state_d = S_DONE;
                    end else if (w_misal) begin
                        mis_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (TIMEOUT != 0) cnt_d = cnt_q + CW'(1);
                if (dmem.gnt) begin
                    state_d = wen_q ? S_DONE : S_WAIT;
                end else if (w_timeout) begin
                    fault_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_WAIT: begin
                if (TIMEOUT != 0) cnt_d = cnt_q + CW'(1);
                if (dmem.rvalid) begin
                    rdata_d = w_load;
                    state_d = S_DONE;
                end else if (w_timeout) begin
                    fault_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (i_ready) begin
                    rdata_d = 32'd0;
                    mis_d   = 1'b0;
                    fault_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            mask_q  <= 4'd0;
            f3_q    <= 3'd0;
            wen_q   <= 1'b0;
            rdata_q <= 32'd0;
            mis_q   <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            f3_q    <= f3_d;
            wen_q   <= wen_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    // Bus fields are only driven while a request is outstanding.
    assign dmem.req   = (state_q == S_REQ);
    assign dmem.addr  = dmem.req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign dmem.wen   = dmem.req & wen_q;
    assign dmem.wdata = dmem.req ? wdata_q : 32'd0;
    assign dmem.mask  = dmem.req ? mask_q : 4'd0;

    assign o_ready      = (state_q == S_IDLE) && !i_rst;
    assign o_valid      = (state_q == S_DONE);
    assign o_rdata      = rdata_q;
    assign o_misaligned = mis_q;
    assign o_fault      = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu.sv
// ============================================================================
//  Module : tb_lsu
//  Brief  : Directed self-checking bench for lsu with a response scoreboard.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_lsu;

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        i_ren;
    logic        i_wen;
    logic [2:0]  i_funct3;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_rdata;
    logic        o_misaligned;
    logic        o_fault;

    lsu_if dmem ();

    lsu #(.TIMEOUT(4)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .i_ren        (i_ren),
        .i_wen        (i_wen),
        .i_funct3     (i_funct3),
        .dmem         (dmem),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_rdata      (o_rdata),
        .o_misaligned (o_misaligned),
        .o_fault      (o_fault)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        mis;
        logic        fault;
    } resp_t;

    resp_t sb_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] wd,
                         input logic rn, input logic wn, input logic [2:0] f3);
        i_valid  = 1'b1;
        i_addr   = a;
        i_wdata  = wd;
        i_ren    = rn;
        i_wen    = wn;
        i_funct3 = f3;
        tick();
        i_valid  = 1'b0;
        i_ren    = 1'b0;
        i_wen    = 1'b0;
    endtask

    task automatic expect_resp(input string tag);
        resp_t e;
        int    k;
        k = 0;
        while (o_valid !== 1'b1 && k < 16) begin
            tick();
            k++;
        end
        chk({tag, "_valid"}, 32'(o_valid), 32'd1);
        chk({tag, "_sb"}, 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) e = sb_q.pop_front();
        else e = '0;
        chk({tag, "_rdata"}, o_rdata, e.rdata);
        chk({tag, "_mis"}, 32'(o_misaligned), 32'(e.mis));
        chk({tag, "_fault"}, 32'(o_fault), 32'(e.fault));
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk({tag, "_vdrop"}, 32'(o_valid), 32'd0);
        chk({tag, "_rdy"}, 32'(o_ready), 32'd1);
    endtask

    task automatic do_load(input logic [31:0] a, input logic [2:0] f3,
                           input logic [31:0] rd, input logic [31:0] exp, input string tag);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        issue(a, 32'd0, 1'b1, 1'b0, f3);
        sb_q.push_back(resp_t'{exp, 1'b0, 1'b0});
        chk({tag, "_req"}, 32'(dmem.req), 32'd1);
        chk({tag, "_addr"}, dmem.addr, wa);
        chk({tag, "_wen"}, 32'(dmem.wen), 32'd0);
        dmem.gnt = 1'b1;
        tick();
        dmem.gnt = 1'b0;
        chk({tag, "_wait_req"}, 32'(dmem.req), 32'd0);
        dmem.rvalid = 1'b1;
        dmem.rdata  = rd;
        tick();
        dmem.rvalid = 1'b0;
        expect_resp(tag);
    endtask

    initial begin
        i_rst = 1'b0; i_valid = 1'b0; i_addr = '0; i_wdata = '0;
        i_ren = 1'b0; i_wen = 1'b0; i_funct3 = '0; i_ready = 1'b0;
        dmem.gnt = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = '0;

        // Reset state
        #2 i_rst = 1'b1;
        #1;
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_req", 32'(dmem.req), 32'd0);
        chk("rst_rdata", o_rdata, 32'd0);
        tick();
        tick();
        i_rst = 1'b0;
        #1;
        chk("idle_ready", 32'(o_ready), 32'd1);

        // i_valid without ren/wen is ignored
        issue(32'h1000, 32'd0, 1'b0, 1'b0, 3'b010);
        chk("nop_ready", 32'(o_ready), 32'd1);
        chk("nop_req", 32'(dmem.req), 32'd0);

        // sb 0x1003, immediate grant
        issue(32'h1003, 32'h0000_00AB, 1'b0, 1'b1, 3'b000);
        sb_q.push_back(resp_t'{32'd0, 1'b0, 1'b0});
        chk("sb_req", 32'(dmem.req), 32'd1);
        chk("sb_addr", dmem.addr, 32'h1000);
        chk("sb_wen", 32'(dmem.wen), 32'd1);
        chk("sb_mask", 32'(dmem.mask), 32'h8);
        chk("sb_wdata", dmem.wdata, 32'hABAB_ABAB);
        dmem.gnt = 1'b1;
        tick();
        dmem.gnt = 1'b0;
        chk("sb_valid_next", 32'(o_valid), 32'd1);
        expect_resp("sb");

        // sh 0x1002
        issue(32'h1002, 32'h5555_1234, 1'b0, 1'b1, 3'b001);
        sb_q.push_back(resp_t'{32'd0, 1'b0, 1'b0});
        chk("sh_mask", 32'(dmem.mask), 32'hC);
        chk("sh_wdata", dmem.wdata, 32'h1234_1234);
        dmem.gnt = 1'b1;
        tick();
        dmem.gnt = 1'b0;
        expect_resp("sh");

        // Loads with extraction/extension
        do_load(32'h2001, 3'b000, 32'h0000_8000, 32'hFFFF_FF80, "lb");
        do_load(32'h2001, 3'b100, 32'h0000_8000, 32'h0000_0080, "lbu");
        do_load(32'h2002, 3'b101, 32'hBEEF_0000, 32'h0000_BEEF, "lhu");
        do_load(32'h2002, 3'b001, 32'hBEEF_0000, 32'hFFFF_BEEF, "lh");
        do_load(32'h2000, 3'b010, 32'h1234_5678, 32'h1234_5678, "lw");

        // Misaligned word: no request, response next cycle
        issue(32'h2002, 32'd0, 1'b1, 1'b0, 3'b010);
        sb_q.push_back(resp_t'{32'd0, 1'b1, 1'b0});
        chk("mis_req", 32'(dmem.req), 32'd0);
        chk("mis_valid_next", 32'(o_valid), 32'd1);
        expect_resp("mis");

        // Illegal funct3
        issue(32'h2000, 32'd0, 1'b1, 1'b0, 3'b011);
        sb_q.push_back(resp_t'{32'd0, 1'b0, 1'b1});
        chk("ill_req", 32'(dmem.req), 32'd0);
        expect_resp("ill");

        // sw with grant held off 3 cycles; response held 2 cycles
        issue(32'h3000, 32'hDEAD_BEEF, 1'b0, 1'b1, 3'b010);
        sb_q.push_back(resp_t'{32'd0, 1'b0, 1'b0});
        for (int i = 0; i < 4; i++) begin
            chk("sw_req", 32'(dmem.req), 32'd1);
            chk("sw_addr", dmem.addr, 32'h3000);
            chk("sw_wdata", dmem.wdata, 32'hDEAD_BEEF);
            chk("sw_mask", 32'(dmem.mask), 32'hF);
            if (i == 3) dmem.gnt = 1'b1;
            tick();
        end
        dmem.gnt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("sw_hold_valid", 32'(o_valid), 32'd1);
            chk("sw_hold_fault", 32'(o_fault), 32'd0);
            tick();
        end
        expect_resp("sw");

        // Timeout after 4 REQ cycles without grant
        issue(32'h4000, 32'd0, 1'b1, 1'b0, 3'b010);
        sb_q.push_back(resp_t'{32'd0, 1'b0, 1'b1});
        for (int i = 0; i < 4; i++) begin
            chk("to_req", 32'(dmem.req), 32'd1);
            tick();
        end
        chk("to_req_drop", 32'(dmem.req), 32'd0);
        chk("to_valid", 32'(o_valid), 32'd1);
        expect_resp("to");

        // Reset while in WAIT
        issue(32'h5000, 32'd0, 1'b1, 1'b0, 3'b010);
        dmem.gnt = 1'b1;
        tick();
        dmem.gnt = 1'b0;
        #2 i_rst = 1'b1;
        #1;
        chk("rstw_req", 32'(dmem.req), 32'd0);
        chk("rstw_valid", 32'(o_valid), 32'd0);
        chk("rstw_ready", 32'(o_ready), 32'd0);
        tick();
        i_rst = 1'b0;
        dmem.rvalid = 1'b1;
        dmem.rdata  = 32'hFFFF_FFFF;
        tick();
        dmem.rvalid = 1'b0;
        chk("rstw_late_valid", 32'(o_valid), 32'd0);
        chk("rstw_late_ready", 32'(o_ready), 32'd1);
        do_load(32'h5004, 3'b010, 32'hCAFE_F00D, 32'hCAFE_F00D, "post_rst_lw");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
